// File: rtl/mul_fp16_arbiter_pkg.sv
// Shared types and constants for the FP16 multiplier arbiter and its
// single-cycle multiplier.
package mul_fp16_arbiter_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NREQ_DEFAULT = 4;

    localparam fp16_t FP16_QNAN = 16'h7E00;

    function automatic fp16_t fp16_inf(input logic sign);
        return {sign, 5'h1F, 10'h000};
    endfunction

endpackage

// File: rtl/mul_fp16_singlecycle.sv
// FP16 multiplier with one register stage: operands presented with start,
// product and done appear on the following cycle. Subnormals flush to zero.
module mul_fp16_singlecycle
    import mul_fp16_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  fp16_t a,
    input  fp16_t b,
    output logic  done,
    output fp16_t result
);

    logic        done_q;
    fp16_t       result_q;
    fp16_t       prod_s;
    logic        sign_s;
    logic [4:0]  ea_s;
    logic [4:0]  eb_s;
    logic        a_nan_s;
    logic        b_nan_s;
    logic        a_inf_s;
    logic        b_inf_s;
    logic        a_zero_s;
    logic        b_zero_s;
    logic [21:0] p_s;
    logic [9:0]  frac_s;
    logic        guard_s;
    logic        sticky_s;
    logic [10:0] rnd_s;
    logic [6:0]  ebias_s;

    // Combinational product: normalise, round to nearest even, then classify.
    always_comb begin
        sign_s   = a[15] ^ b[15];
        ea_s     = a[14:10];
        eb_s     = b[14:10];
        a_nan_s  = (ea_s == 5'h1F) && (a[9:0] != 10'h000);
        b_nan_s  = (eb_s == 5'h1F) && (b[9:0] != 10'h000);
        a_inf_s  = (ea_s == 5'h1F) && (a[9:0] == 10'h000);
        b_inf_s  = (eb_s == 5'h1F) && (b[9:0] == 10'h000);
        a_zero_s = (ea_s == 5'h00);
        b_zero_s = (eb_s == 5'h00);
        p_s      = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        if (p_s[21]) begin
            frac_s   = p_s[20:11];
            guard_s  = p_s[10];
            sticky_s = |p_s[9:0];
        end else begin
            frac_s   = p_s[19:10];
            guard_s  = p_s[9];
            sticky_s = |p_s[8:0];
        end
        rnd_s   = {1'b0, frac_s} + {10'd0, guard_s & (sticky_s | frac_s[0])};
        // Biased sum carries the +15 offset twice; legal range is 16..45.
        ebias_s = 7'(ea_s) + 7'(eb_s) + 7'(p_s[21]) + 7'(rnd_s[10]);
        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            prod_s = FP16_QNAN;
        end else if (a_inf_s || b_inf_s) begin
            prod_s = fp16_inf(sign_s);
        end else if (a_zero_s || b_zero_s) begin
            prod_s = {sign_s, 15'h0000};
        end else if (ebias_s >= 7'd46) begin
            prod_s = fp16_inf(sign_s);
        end else if (ebias_s <= 7'd15) begin
            prod_s = {sign_s, 15'h0000};
        end else begin
            prod_s = {sign_s, 5'(ebias_s - 7'd15), rnd_s[9:0]};
        end
    end

    // Output register: capture the product only when started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            result_q <= 16'h0000;
        end else begin
            done_q <= start;
            if (start) begin
                result_q <= prod_s;
            end else begin
                result_q <= result_q;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: rtl/mul_fp16_arbiter.sv
// Round-robin arbiter sharing one FP16 multiplier among NREQ requesters,
// with a held response register for the owning requester.
module mul_fp16_arbiter
    import mul_fp16_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  fp16_t [NREQ-1:0]          req_a,
    input  fp16_t [NREQ-1:0]          req_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output fp16_t                     resp_result,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    state_e          state_q;
    state_e          state_d;
    logic [IDW-1:0]  last_grant_q;
    logic            resp_valid_q;
    fp16_t           resp_result_q;
    logic [IDW-1:0]  resp_id_q;
    logic [IDW:0]    pick_s;
    logic            grant_s;
    logic            capture_s;
    logic            release_s;
    logic [NREQ-1:0] ready_s;
    fp16_t           mul_a_s;
    fp16_t           mul_b_s;
    logic            mul_done_s;
    fp16_t           mul_result_s;

    // Returns {found, index}; search begins just after the last grant.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
        logic           found;
        logic [IDW-1:0] idx;
        found = 1'b0;
        idx   = {IDW{1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && valid[(int'(last) + i) % NREQ]) begin
                found = 1'b1;
                idx   = IDW'((int'(last) + i) % NREQ);
            end
        end
        return {found, idx};
    endfunction

    assign pick_s  = rr_pick(req_valid, last_grant_q);
    assign mul_a_s = req_a[pick_s[IDW-1:0]];
    assign mul_b_s = req_b[pick_s[IDW-1:0]];

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        grant_s   = 1'b0;
        capture_s = 1'b0;
        release_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_s[IDW] && !RST) begin
                    grant_s = 1'b1;
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                // Without done the FSM parks here rather than invent a result.
                if (mul_done_s) begin
                    capture_s = 1'b1;
                    state_d   = RESP;
                end else begin
                    state_d = MUL;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    release_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is one-hot on the granted requester, only in the grant cycle.
    always_comb begin
        ready_s = {NREQ{1'b0}};
        if (grant_s) begin
            ready_s = NREQ'(1) << pick_s[IDW-1:0];
        end else begin
            ready_s = {NREQ{1'b0}};
        end
    end

    // State, pointer and response registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            last_grant_q  <= IDW'(NREQ - 1);
            resp_valid_q  <= 1'b0;
            resp_result_q <= 16'h0000;
            resp_id_q     <= {IDW{1'b0}};
        end else begin
            state_q <= state_d;
            if (grant_s) begin
                last_grant_q <= pick_s[IDW-1:0];
            end else begin
                last_grant_q <= last_grant_q;
            end
            if (capture_s) begin
                resp_valid_q  <= 1'b1;
                resp_result_q <= mul_result_s;
                resp_id_q     <= last_grant_q;
            end else if (release_s) begin
                resp_valid_q  <= 1'b0;
            end else begin
                resp_valid_q  <= resp_valid_q;
            end
        end
    end

    mul_fp16_singlecycle u_mul (
        .clk    (clk),
        .rst_n  (~RST),
        .start  (grant_s),
        .a      (mul_a_s),
        .b      (mul_b_s),
        .done   (mul_done_s),
        .result (mul_result_s)
    );

    assign req_ready   = ready_s;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_id     = resp_id_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mul_fp16_arbiter.sv
// Directed bench for mul_fp16_arbiter: a vector table of single operations
// followed by hand-written backpressure, reset-abort and fairness sequences.
module tb_mul_fp16_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  exp_id;
        logic [15:0] exp_res;
    } vec_t;

    logic              clk;
    logic              RST;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0][15:0] req_a;
    logic [NREQ-1:0][15:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [15:0]       resp_result;
    logic              busy;

    int checks = 0;
    int errors = 0;
    vec_t vecs [8];

    mul_fp16_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = a;
            req_b[i] = b;
        end
    endtask

    // Waits (bounded) until the current IDLE cycle shows a grant.
    task automatic wait_grant(input string name);
        int c;
        c = 0;
        while (req_ready == 4'b0000 && c < 10) begin
            tick();
            c++;
        end
        if (req_ready == 4'b0000) begin
            chk({name, "_grant_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string nm;
        nm = $sformatf("vec%0d", n);
        req_valid  = v.rv;
        resp_ready = 1'b1;
        set_ops(v.a, v.b);
        #1;
        wait_grant(nm);
        chk({nm, "_ready"}, 32'(req_ready), 32'(4'b0001 << v.exp_id));
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
        tick();
        req_valid = 4'b0000;
        set_ops(16'hFFFF, 16'hFFFF);
        #1;
        chk({nm, "_mul_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, "_mul_ready"}, 32'(req_ready), 32'd0);
        tick();
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_result"}, 32'(resp_result), 32'(v.exp_res));
        chk({nm, "_id"}, 32'(resp_id), 32'(v.exp_id));
        tick();
        chk({nm, "_released"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 16'h4000, 16'h4200, 2'd0, 16'h4600};
        vecs[1] = '{4'b0010, 16'hBE00, 16'h4000, 2'd1, 16'hC200};
        vecs[2] = '{4'b1000, 16'h0000, 16'h3C00, 2'd3, 16'h0000};
        vecs[3] = '{4'b1111, 16'h3C00, 16'h3C00, 2'd0, 16'h3C00};
        vecs[4] = '{4'b0110, 16'h3E00, 16'h3E00, 2'd1, 16'h4080};
        vecs[5] = '{4'b0110, 16'h7BFF, 16'h4000, 2'd2, 16'h7C00};
        vecs[6] = '{4'b0001, 16'h7C00, 16'h0000, 2'd0, 16'h7E00};
        vecs[7] = '{4'b1010, 16'h3C01, 16'h3E00, 2'd1, 16'h3E02};

        RST        = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        set_ops(16'h3C00, 16'h3C00);
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        @(negedge clk);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: response held for five cycles, requester kept valid.
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        set_ops(16'hBE00, 16'h4000);
        #1;
        wait_grant("hold");
        chk("hold_ready", 32'(req_ready), 32'h4);
        tick();
        set_ops(16'h0000, 16'h0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_result", 32'(resp_result), 32'hC200);
            chk("hold_id", 32'(resp_id), 32'd2);
            chk("hold_ready0", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            tick();
        end
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        #1;
        chk("hold_release_ready", 32'(req_ready), 32'd0);
        tick();
        chk("hold_released", 32'(resp_valid), 32'd0);
        chk("hold_idle_busy", 32'(busy), 32'd0);

        // Reset while the product is in flight: it must never be presented.
        req_valid = 4'b0100;
        set_ops(16'h4000, 16'h4200);
        #1;
        wait_grant("abort");
        chk("abort_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("abort_in_mul", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end

        // Fairness: all requesters valid, eight back-to-back operations.
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        set_ops(16'h3C00, 16'h3C00);
        #1;
        for (int k = 0; k < 8; k++) begin
            wait_grant("rr");
            chk("rr_order", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            tick();
            chk("rr_result", 32'(resp_result), 32'h3C00);
            chk("rr_id", 32'(resp_id), 32'(k % 4));
            tick();
        end
        req_valid = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
